// File: rtl/async_fifo_rd_stream_pkg.sv
// Shared constants and types for the async FIFO read-side streamer.
// Stats counters are enabled by defining ASYNC_FIFO_RD_STATS_EN.
package Asynchronous_FIFO_pkg;

   localparam int DATA_WIDTH   = 8;
   localparam int RD_LATENCY   = 1;
   localparam int RD_BUF_DEPTH = 3;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      FLUSH  = 2'd2
   } rd_stream_state_t;

   // A one-entry buffer still needs a 1-bit pointer.
   function automatic int ptr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/async_fifo_rd_stream_skid_buf.sv
// Circular skid buffer between the FIFO read pipeline and the downstream stream.
// clear empties the buffer and takes priority over a same-cycle write or pop.
module rd_skid_buf #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 3,
   parameter int OCC_W      = $clog2(DEPTH + 1)
) (
   input  logic                  clk_rd,
   input  logic                  rst_n,
   input  logic                  clear,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  pop,
   output logic [DATA_WIDTH-1:0] head_data,
   output logic [OCC_W-1:0]      occ
);
   import Asynchronous_FIFO_pkg::*;

   localparam int PTR_W = ptr_width(DEPTH);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0]      head_q, head_d;
   logic [PTR_W-1:0]      tail_q, tail_d;
   logic [OCC_W-1:0]      occ_q, occ_d;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   always_comb begin
      mem_d  = mem_q;
      head_d = head_q;
      tail_d = tail_q;
      occ_d  = occ_q;
      if (clear) begin
         head_d = '0;
         tail_d = '0;
         occ_d  = '0;
      end else begin
         if (wr_en) begin
            mem_d[tail_q] = wr_data;
            tail_d        = next_ptr(tail_q);
         end
         if (pop) begin
            head_d = next_ptr(head_q);
         end
         case ({wr_en, pop})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
         endcase
      end
   end

   always_ff @(posedge clk_rd or negedge rst_n) begin
      if (!rst_n) begin
         mem_q  <= '{default: '0};
         head_q <= '0;
         tail_q <= '0;
         occ_q  <= '0;
      end else begin
         mem_q  <= mem_d;
         head_q <= head_d;
         tail_q <= tail_d;
         occ_q  <= occ_d;
      end
   end

   assign head_data = mem_q[head_q];
   assign occ       = occ_q;

endmodule

// File: rtl/async_fifo_rd_stream.sv
// Read-side consumer of the async FIFO: credit-based rd_en, latency-matched capture,
// valid/ready output and flush. Optional ASYNC_FIFO_RD_STATS_EN adds word/stall counters.
//
// state  | meaning
// IDLE   | first cycle after reset release, no reads issued
// STREAM | reads issued against buffer credit, words presented downstream
// FLUSH  | buffer cleared, in-flight words discarded until the pipeline is empty
module async_fifo_rd_stream #(
   parameter int DATA_WIDTH = Asynchronous_FIFO_pkg::DATA_WIDTH,
   parameter int RD_LATENCY = Asynchronous_FIFO_pkg::RD_LATENCY,
   parameter int BUF_DEPTH  = Asynchronous_FIFO_pkg::RD_BUF_DEPTH
) (
   input  logic                  clk_rd,
   input  logic                  rst_n,
   input  logic                  empty,
   input  logic [DATA_WIDTH-1:0] data_out,
   output logic                  rd_en,
   input  logic                  flush,
   output logic                  flush_busy,
   output logic                  m_valid,
   input  logic                  m_ready,
`ifdef ASYNC_FIFO_RD_STATS_EN
   output logic [31:0]           word_cnt,
   output logic [31:0]           stall_cnt,
`endif
   output logic [DATA_WIDTH-1:0] m_data
);
   import Asynchronous_FIFO_pkg::*;

   localparam int OCC_W = $clog2(BUF_DEPTH + 1);

   if (RD_LATENCY < 1 || RD_LATENCY > 4 || BUF_DEPTH < RD_LATENCY + 2) begin : g_bad_cfg
      $error("async_fifo_rd_stream: need 1 <= RD_LATENCY <= 4 and BUF_DEPTH >= RD_LATENCY+2");
   end

   rd_stream_state_t      state_q, state_d;
   logic [RD_LATENCY-1:0] inflight_q, inflight_d;
   logic [OCC_W-1:0]      occ;
   logic [DATA_WIDTH-1:0] head_data;
   logic                  credit_ok;
   logic                  capture;
   logic                  buf_clear;
   logic                  buf_wr;
   logic                  buf_pop;

   // Credit counts words already read but not yet landed, so the buffer can never overflow.
   assign capture   = inflight_q[RD_LATENCY-1];
   assign credit_ok = (int'(occ) + $countones(inflight_q)) < BUF_DEPTH;

   always_ff @(posedge clk_rd or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         inflight_q <= '0;
      end else begin
         state_q    <= state_d;
         inflight_q <= inflight_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = STREAM;
         STREAM:  if (flush) state_d = FLUSH;
         FLUSH:   if (inflight_q == '0 && !flush) state_d = STREAM;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      rd_en      = (state_q == STREAM) && !empty && credit_ok;
      m_valid    = (occ != '0) && (state_q != FLUSH);
      flush_busy = (state_q == FLUSH);
      buf_clear  = (state_q == STREAM) && flush;
      buf_wr     = capture && (state_q == STREAM) && !flush;
      buf_pop    = m_valid && m_ready;
   end

   always_comb begin
      inflight_d = (inflight_q << 1) | RD_LATENCY'(rd_en);
   end

   rd_skid_buf #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (BUF_DEPTH),
      .OCC_W      (OCC_W)
   ) u_skid_buf (
      .clk_rd    (clk_rd),
      .rst_n     (rst_n),
      .clear     (buf_clear),
      .wr_en     (buf_wr),
      .wr_data   (data_out),
      .pop       (buf_pop),
      .head_data (head_data),
      .occ       (occ)
   );

   assign m_data = head_data;

`ifdef ASYNC_FIFO_RD_STATS_EN
   logic [31:0] word_cnt_q, word_cnt_d;
   logic [31:0] stall_cnt_q, stall_cnt_d;

   always_comb begin
      word_cnt_d  = word_cnt_q;
      stall_cnt_d = stall_cnt_q;
      if (buf_clear) begin
         word_cnt_d  = '0;
         stall_cnt_d = '0;
      end else begin
         if (buf_pop) word_cnt_d = word_cnt_q + 32'd1;
         if (m_valid && !m_ready) stall_cnt_d = stall_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk_rd or negedge rst_n) begin
      if (!rst_n) begin
         word_cnt_q  <= '0;
         stall_cnt_q <= '0;
      end else begin
         word_cnt_q  <= word_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign word_cnt  = word_cnt_q;
   assign stall_cnt = stall_cnt_q;
`endif

   a_occ_bound: assert property (@(posedge clk_rd) disable iff (!rst_n) int'(occ) <= BUF_DEPTH);
   a_no_rd_empty: assert property (@(posedge clk_rd) disable iff (!rst_n) !(rd_en && empty));

endmodule

// File: tb/tb_async_fifo_rd_stream.sv
// Self-checking bench for async_fifo_rd_stream: hand-derived vector table, directed
// reset/flush sequences and a randomized run against a queue-based reference model.
module tb_async_fifo_rd_stream;
   import Asynchronous_FIFO_pkg::*;

   localparam int DW = DATA_WIDTH;
   localparam int L  = RD_LATENCY;
   localparam int D  = RD_BUF_DEPTH;

   logic          clk_rd = 1'b0;
   logic          rst_n = 1'b0;
   logic          empty = 1'b0;
   logic [DW-1:0] data_out = '0;
   logic          rd_en;
   logic          flush = 1'b0;
   logic          flush_busy;
   logic          m_valid;
   logic          m_ready = 1'b0;
   logic [DW-1:0] m_data;
`ifdef ASYNC_FIFO_RD_STATS_EN
   logic [31:0]   word_cnt;
   logic [31:0]   stall_cnt;
`endif

   always #5 clk_rd = ~clk_rd;

   async_fifo_rd_stream dut (
      .clk_rd     (clk_rd),
      .rst_n      (rst_n),
      .empty      (empty),
      .data_out   (data_out),
      .rd_en      (rd_en),
      .flush      (flush),
      .flush_busy (flush_busy),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
`ifdef ASYNC_FIFO_RD_STATS_EN
      .word_cnt   (word_cnt),
      .stall_cnt  (stall_cnt),
`endif
      .m_data     (m_data)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: words sitting in the skid buffer, words requested but not yet landed.
   int            mode;          // 0 idle, 1 streaming, 2 flushing
   logic [DW-1:0] buf_q [$];
   logic [DW-1:0] pipe_w [$];
   int            pipe_c [$];
   logic [DW-1:0] fifo_next = '0;
   int            hs_cnt, st_cnt;

   function automatic void model_reset();
      mode = 0;
      buf_q.delete();
      pipe_w.delete();
      pipe_c.delete();
      hs_cnt = 0;
      st_cnt = 0;
   endfunction

   // Drive one cycle, check against the model at the negedge, then advance model and FIFO.
   task automatic run_cycle(input logic e, input logic r, input logic f,
                            output logic o_rd, output logic o_v,
                            output logic [DW-1:0] o_d, output logic o_b);
      logic          exp_rd, exp_v, s_rd;
      logic [DW-1:0] w;
      int            n_inf;
      empty   = e;
      m_ready = r;
      flush   = f;
      @(negedge clk_rd);
      exp_rd = (mode == 1) && !e && ((buf_q.size() + pipe_w.size()) < D);
      exp_v  = (buf_q.size() != 0) && (mode != 2);
      o_rd = rd_en; o_v = m_valid; o_d = m_data; o_b = flush_busy;
      chk("rd_en", rd_en, exp_rd);
      chk("m_valid", m_valid, exp_v);
      chk("flush_busy", flush_busy, mode == 2);
      chk("rd_en_while_empty", rd_en & e, 0);
      if (exp_v) chk("m_data", m_data, buf_q[0]);
      s_rd = rd_en;
      if (exp_v && r) begin
         void'(buf_q.pop_front());
         hs_cnt++;
      end else if (exp_v) begin
         st_cnt++;
      end
      n_inf = pipe_w.size();
      foreach (pipe_c[i]) pipe_c[i]--;
      while (pipe_c.size() != 0 && pipe_c[0] == 0) begin
         w = pipe_w.pop_front();
         void'(pipe_c.pop_front());
         if (mode == 1 && !f) buf_q.push_back(w);
      end
      case (mode)
         0: mode = 1;
         1: if (f) begin
               mode = 2;
               buf_q.delete();
               hs_cnt = 0;
               st_cnt = 0;
            end
         default: if (n_inf == 0 && !f) mode = 1;
      endcase
      if (exp_rd) begin
         pipe_w.push_back(fifo_next);
         pipe_c.push_back(L);
      end
      @(posedge clk_rd);
      #1;
      if (s_rd) begin
         data_out  = fifo_next;
         fifo_next = fifo_next + 1'b1;
      end
   endtask

   typedef struct {
      logic          e, r, f;
      logic          rd, v;
      logic [DW-1:0] d;
      logic          b;
   } vec_t;

   vec_t tbl [17];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic          o_rd, o_v, o_b;
      logic [DW-1:0] o_d;
      logic [DW-1:0] base;
      bit            seen;

      // Startup, backpressure, FIFO drain and resume; words start at 0x00.
      tbl[0]  = '{0,1,0, 0,0,8'h00,0};
      tbl[1]  = '{0,1,0, 1,0,8'h00,0};
      tbl[2]  = '{0,1,0, 1,0,8'h00,0};
      tbl[3]  = '{0,1,0, 1,1,8'h00,0};
      tbl[4]  = '{0,1,0, 1,1,8'h01,0};
      tbl[5]  = '{0,0,0, 1,1,8'h02,0};
      tbl[6]  = '{0,0,0, 0,1,8'h02,0};
      tbl[7]  = '{0,0,0, 0,1,8'h02,0};
      tbl[8]  = '{0,1,0, 0,1,8'h02,0};
      tbl[9]  = '{0,1,0, 1,1,8'h03,0};
      tbl[10] = '{0,1,0, 1,1,8'h04,0};
      tbl[11] = '{1,1,0, 0,1,8'h05,0};
      tbl[12] = '{1,1,0, 0,1,8'h06,0};
      tbl[13] = '{1,1,0, 0,0,8'h00,0};
      tbl[14] = '{0,1,0, 1,0,8'h00,0};
      tbl[15] = '{0,1,0, 1,0,8'h00,0};
      tbl[16] = '{0,1,0, 1,1,8'h07,0};

      // Reset held with the FIFO non-empty.
      model_reset();
      empty = 1'b0;
      repeat (3) @(negedge clk_rd);
      chk("reset_rd_en", rd_en, 0);
      chk("reset_m_valid", m_valid, 0);
      chk("reset_m_data", m_data, 0);
      chk("reset_flush_busy", flush_busy, 0);
      @(posedge clk_rd); #1;
      rst_n = 1'b1;

      for (int i = 0; i < 17; i++) begin
         run_cycle(tbl[i].e, tbl[i].r, tbl[i].f, o_rd, o_v, o_d, o_b);
         chk($sformatf("tbl%0d_rd_en", i), o_rd, tbl[i].rd);
         chk($sformatf("tbl%0d_m_valid", i), o_v, tbl[i].v);
         chk($sformatf("tbl%0d_flush_busy", i), o_b, tbl[i].b);
         if (tbl[i].v) chk($sformatf("tbl%0d_m_data", i), o_d, tbl[i].d);
      end

      // Asynchronous reset between edges mid-stream.
      repeat (4) run_cycle(0, 1, 0, o_rd, o_v, o_d, o_b);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_rd_en", rd_en, 0);
      chk("async_rst_m_valid", m_valid, 0);
      chk("async_rst_m_data", m_data, 0);
      chk("async_rst_flush_busy", flush_busy, 0);
`ifdef ASYNC_FIFO_RD_STATS_EN
      chk("async_rst_word_cnt", word_cnt, 0);
`endif
      model_reset();
      repeat (2) @(posedge clk_rd);
      #1;
      rst_n = 1'b1;

      // Flush with two words buffered and one in flight.
      base = fifo_next;
      repeat (4) run_cycle(0, 0, 0, o_rd, o_v, o_d, o_b);
      run_cycle(0, 0, 1, o_rd, o_v, o_d, o_b);
      chk("flush_cycle_rd_en", o_rd, 0);
      run_cycle(0, 0, 0, o_rd, o_v, o_d, o_b);
      chk("flush_busy_first", o_b, 1);
      chk("flush_m_valid", o_v, 0);
      run_cycle(0, 1, 0, o_rd, o_v, o_d, o_b);
      chk("flush_busy_done", o_b, 0);
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         run_cycle(0, 1, 0, o_rd, o_v, o_d, o_b);
         if (o_v) begin
            seen = 1'b1;
            chk("post_flush_word", o_d, base + DW'(3));
         end
      end
      chk("post_flush_word_seen", seen, 1);

      // Randomized traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         run_cycle(($urandom % 4) == 0, ($urandom % 3) != 0, ($urandom % 40) == 0,
                   o_rd, o_v, o_d, o_b);
      end
`ifdef ASYNC_FIFO_RD_STATS_EN
      chk("word_cnt", word_cnt, 64'(hs_cnt));
      chk("stall_cnt", stall_cnt, 64'(st_cnt));
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
